led_seq_ctrl: RTL and testbench

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

---
 rtl/led_pkg.sv | 19 +
 rtl/led_tick.sv | 29 ++
 rtl/led_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_led_seq_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and constants for the LED sequencer.
// Mode enumeration and button bit positions.
package led_pkg;

   typedef enum logic [1:0] {
      MIRROR = 2'd0,
      CHASE  = 2'd1,
      COUNT  = 2'd2,
      PWM    = 2'd3
   } mode_e;

   localparam int BTN_MODE  = 0;
   localparam int BTN_DIR   = 1;
   localparam int BTN_UP    = 2;
   localparam int BTN_DN    = 3;
   localparam int BTN_PAUSE = 4;
   localparam int NUM_BTN   = 5;

endpackage

// File: rtl/led_tick.sv
// Free-running prescaler producing a one-cycle step tick
// every PRESCALE clocks.
module led_tick #(
   parameter int PRESCALE = 5000000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = tick ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: mirror, chase, binary count and PWM dimming,
// driven by debounced-by-edge button presses.
module led_seq_ctrl
   import led_pkg::*;
#(
   parameter int NUM_LED  = 16,
   parameter int PRESCALE = 5000000,
   parameter int PWM_BITS = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [4:0]         btn,
   input  logic [NUM_LED-1:0] sw,
   output logic [NUM_LED-1:0] ledr,
   output logic [1:0]         mode
);

   localparam logic [PWM_BITS-1:0] DUTY_RST =
      {1'b1, {(PWM_BITS-1){1'b0}}};
   localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
   localparam logic [NUM_LED-1:0]  ONE_HOT0 =
      {{(NUM_LED-1){1'b0}}, 1'b1};

   logic [NUM_BTN-1:0] press;
   logic               tick;

   // Two-flop synchroniser plus a history flop; one pulse per press.
   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      logic s1_q, s2_q, hist_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            s1_q   <= 1'b0;
            s2_q   <= 1'b0;
            hist_q <= 1'b0;
         end else begin
            s1_q   <= btn[i];
            s2_q   <= s1_q;
            hist_q <= s2_q;
         end
      end

      assign press[i] = s2_q & ~hist_q;
   end

   led_tick #(
      .PRESCALE(PRESCALE)
   ) u_tick (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   mode_e               mode_q, mode_d;
   logic                dir_q, dir_d;
   logic                pause_q, pause_d;
   logic [PWM_BITS-1:0] duty_q, duty_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [NUM_LED-1:0]  chase_q, chase_d;
   logic [NUM_LED-1:0]  cnt_q, cnt_d;
   logic [NUM_LED-1:0]  ledr_q, ledr_d;
   logic                step;
   logic                pwm_on;

   always_comb begin
      mode_d  = mode_q;
      dir_d   = dir_q ^ press[BTN_DIR];
      pause_d = pause_q ^ press[BTN_PAUSE];
      duty_d  = duty_q;
      pwm_d   = pwm_q + 1'b1;
      chase_d = chase_q;
      cnt_d   = cnt_q;
      ledr_d  = '0;
      step    = tick & ~pause_q;
      pwm_on  = (pwm_q < duty_q);

      // Mode change reinitialises and swallows a coincident step.
      if (press[BTN_MODE]) begin
         mode_d  = mode_e'(mode_q + 2'd1);
         chase_d = ONE_HOT0;
         cnt_d   = '0;
      end else if (step) begin
         if (mode_q == CHASE) begin
            chase_d = dir_q
               ? {chase_q[0], chase_q[NUM_LED-1:1]}
               : {chase_q[NUM_LED-2:0], chase_q[NUM_LED-1]};
         end
         if (mode_q == COUNT) begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      if (press[BTN_UP] && !press[BTN_DN]
          && duty_q != DUTY_MAX) begin
         duty_d = duty_q + 1'b1;
      end else if (press[BTN_DN] && !press[BTN_UP]
                   && duty_q != '0) begin
         duty_d = duty_q - 1'b1;
      end

      unique case (mode_q)
         MIRROR: ledr_d = sw;
         CHASE:  ledr_d = chase_q;
         COUNT:  ledr_d = cnt_q;
         PWM:    ledr_d = sw & {NUM_LED{pwm_on}};
         default: ledr_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q  <= MIRROR;
         dir_q   <= 1'b0;
         pause_q <= 1'b0;
         duty_q  <= DUTY_RST;
         pwm_q   <= '0;
         chase_q <= ONE_HOT0;
         cnt_q   <= '0;
         ledr_q  <= '0;
      end else begin
         mode_q  <= mode_d;
         dir_q   <= dir_d;
         pause_q <= pause_d;
         duty_q  <= duty_d;
         pwm_q   <= pwm_d;
         chase_q <= chase_d;
         cnt_q   <= cnt_d;
         ledr_q  <= ledr_d;
      end
   end

   assign ledr = ledr_q;
   assign mode = mode_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed and random stimulus for led_seq_ctrl, checked every
// cycle against an edge-count based reference model.
module tb_led_seq_ctrl;

   localparam int NL = 8;
   localparam int PS = 4;
   localparam int PB = 4;
   localparam int PW = 1 << PB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [4:0]    btn = '0;
   logic [NL-1:0] sw  = '0;
   logic [NL-1:0] ledr;
   logic [1:0]    mode;

   int total = 0;
   int bad   = 0;

   // Reference state, plain integers.
   int         m_mode, m_dir, m_pause, m_duty;
   int         m_pos, m_cnt, m_since;
   logic [7:0] m_led;
   logic [4:0] h0, h1, h2;

   led_seq_ctrl #(
      .NUM_LED (NL),
      .PRESCALE(PS),
      .PWM_BITS(PB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .btn (btn),
      .sw  (sw),
      .ledr(ledr),
      .mode(mode)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Apply one rising edge to the model using the held inputs.
   task automatic model_edge();
      logic [4:0] act;
      int         pwmv;
      bit         tk;
      if (rst) begin
         m_led = '0; m_mode = 0; m_dir = 0; m_pause = 0;
         m_duty = PW / 2; m_pos = 0; m_cnt = 0; m_since = 0;
         h0 = '0; h1 = '0; h2 = '0;
         return;
      end
      pwmv = m_since % PW;
      m_since++;
      tk  = (m_since % PS) == 0;
      act = h1 & ~h2;
      case (m_mode)
         0: m_led = sw;
         1: m_led = 8'(1 << m_pos);
         2: m_led = 8'(m_cnt);
         default: m_led = (pwmv < m_duty) ? sw : 8'h00;
      endcase
      if (act[0]) begin
         m_mode = (m_mode + 1) % 4;
         m_pos  = 0;
         m_cnt  = 0;
      end else if (tk && m_pause == 0) begin
         if (m_mode == 1)
            m_pos = (m_dir != 0) ? (m_pos + NL - 1) % NL
                                 : (m_pos + 1) % NL;
         if (m_mode == 2)
            m_cnt = (m_cnt + 1) % 256;
      end
      if (act[1]) m_dir   = 1 - m_dir;
      if (act[4]) m_pause = 1 - m_pause;
      if (act[2] && !act[3] && m_duty < PW - 1) m_duty++;
      if (act[3] && !act[2] && m_duty > 0)      m_duty--;
      h2 = h1;
      h1 = h0;
      h0 = btn;
   endtask

   task automatic cyc(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         model_edge();
         #1;
         chk("ledr", 32'(ledr), 32'(m_led));
         chk("mode", 32'(mode), 32'(m_mode));
      end
   endtask

   task automatic press(input logic [4:0] mask);
      btn = mask;
      cyc(3);
      btn = '0;
      cyc(3);
   endtask

   initial begin
      // Reset state.
      rst = 1'b1;
      cyc(2);
      chk("rst_ledr", 32'(ledr), 32'h0);
      chk("rst_mode", 32'(mode), 32'h0);

      // Mirror with one cycle latency.
      rst = 1'b0;
      sw  = 8'hA5;
      cyc(1);
      chk("mirror_a5", 32'(ledr), 32'hA5);
      sw = 8'h3C;
      cyc(3);

      // Chase left, then reversed.
      press(5'b00001);
      cyc(40);
      press(5'b00010);
      cyc(40);

      // Count with full wrap, then pause/resume.
      press(5'b00001);
      cyc(1100);
      press(5'b10000);
      cyc(24);
      press(5'b10000);
      cyc(24);

      // PWM at reset duty, then floor, ceiling and simultaneous.
      sw = 8'h0F;
      press(5'b00001);
      cyc(40);
      for (int i = 0; i < 10; i++) press(5'b01000);
      cyc(40);
      for (int i = 0; i < 20; i++) press(5'b00100);
      cyc(40);
      press(5'b01100);
      cyc(40);
      sw = 8'hF3;
      cyc(20);

      // Mode pulse coincides with a tick while in CHASE.
      press(5'b00001);
      press(5'b00001);
      cyc(10);
      while (m_since % PS != 1) cyc(1);
      btn = 5'b00001;
      cyc(3);
      chk("tick_mode", 32'(mode), 32'h2);
      btn = '0;
      cyc(1);
      chk("tick_cnt0", 32'(ledr), 32'h0);
      cyc(10);

      // Reset in the middle of a held press.
      press(5'b00001);
      press(5'b00001);
      cyc(2);
      btn = 5'b00001;
      cyc(1);
      rst = 1'b1;
      cyc(1);
      chk("midrst_mode", 32'(mode), 32'h0);
      rst = 1'b0;
      cyc(8);
      btn = '0;
      cyc(6);
      chk("midrst_once", 32'(mode), 32'h1);

      // Random buttons, switches and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         sw = 8'($urandom);
         for (int b = 0; b < 5; b++)
            if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
         rst = ($urandom_range(0, 299) == 0);
         cyc(1);
      end
      rst = 1'b0;
      btn = '0;
      cyc(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
